seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multi-digit 7-segment display controller with time-multiplexed scanning. Accepts a value through a valid/ready handshake in either hex mode (direct nibbles) or decimal mode (binary converted to BCD by an iterative double-dabble engine). It holds the value in a display register and scans one digit at a time onto a shared segment bus with one-hot digit enables. It sits between user logic and board 7-segment pins, and is the successor to the per-digit combinational decoders.

Parameters:
DIGITS, 4, number of digits (1..8); W = 4*DIGITS.
SCAN_DIV, 50000, clock cycles each digit stays enabled (>=1).
INVERT, 1, 1 = segments/dp active-low (0 lights a segment); 0 = active-high.
ANODE_LOW, 1, 1 = digit enable active-low; 0 = active-high.

Ports:
clk  in  1  system clock
rst  in  1  reset
load_valid  in  1  load request
load_ready  out  1  block can accept a load
load_value  in  W  hex nibbles (hex mode) or unsigned binary (dec mode)
load_dec  in  1  1 = decimal mode for this load
load_dp  in  DIGITS  decimal point per digit, 1 = lit
seg  out  7  segments {g,f,e,d,c,b,a}, bit 6 = g
dp  out  1  decimal point of the scanned digit
an  out  DIGITS  one-hot digit enable
ovf  out  1  last decimal load exceeded 10^DIGITS-1

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - Display nibbles = 0, dp register = 0, ovf = 0, load_ready = 1.
  - Scan index = 0, prescaler = 0, FSM = IDLE.
  - Outputs: seg = '0' pattern (1000000 when INVERT=1), dp off, an selects digit 0.
- FSM states: IDLE, CONV, COMMIT. load_ready = 1 only in IDLE.
- Accept condition: load_valid & load_ready, taken on edge E0.
  - Hex mode (load_dec=0): display ← load_value, dp ← load_dp, ovf ← 0 at E0. Stays in IDLE, so back-to-back loads are allowed every cycle.
  - Dec mode (load_dec=1): at E0 latch load_value into the shift register, clear the BCD register, latch load_dp, set ovf_pending = (load_value >= 10^DIGITS), go to CONV.
  - CONV: one add-3-then-shift iteration per cycle for W cycles (E1..EW), then go to COMMIT.
  - COMMIT (edge EW+1): display ← BCD result, dp ← latched dp, ovf ← ovf_pending, go to IDLE. load_ready is low for exactly W+1 cycles.
- During CONV and COMMIT the previous display contents keep scanning. load_valid is ignored, and the source must hold its request.
- Overflow: when ovf = 1, every digit shows '-' (only g lit: 0111111 for INVERT=1) and dp is forced off.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1.
  - On wrap, the index increments, with DIGITS-1 → 0.
  - SCAN_DIV=1 advances the index every cycle.
- Outputs are registered from (index, display):
  - A display or index change is visible on seg/dp/an one cycle later.
  - an always has exactly one active bit, never zero and never two, including at index wrap.
- Encoding: digits 0-F use the standard table (e.g. 0=1000000, 8=0000000, B=0000011, E=0000110, F=0001110, INVERT=1). Non-BCD nibbles never appear in dec mode.
- Reset mid-conversion: aborts to IDLE, display cleared, no commit.

Optional Feature:
SEG7_LZB_EN: leading-zero blanking.
- With the macro: each display nibble that is 0 and above the most-significant nonzero digit is blanked (all segments off, dp still honoured). Digit 0 is never blanked. Applies in both modes; no effect when ovf = 1.
- Without the macro: all digits are always shown.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK and SEG_DASH constants, and the 16-entry segment table (active-high form).
  - FSM state enum {IDLE, CONV, COMMIT}.
  - Function pow10(DIGITS) for the overflow threshold, 32-bit.
- Sub-module seg7_encode: combinational nibble + blank + dash → 7 segments, INVERT applied once.

Test Plan:
- DIGITS=4, SCAN_DIV=3, hex load 16'hBEEF:
  - an cycles 1110, 1101, 1011, 0111, each for 3 clk.
  - seg = 0001110 (F) on digit 0 and 0000110 (E) on digits 1-2.
  - seg = 0000011 (B) on digit 3.
  - load_ready never drops.
- Dec load 16'd1234:
  - load_ready is low for 17 cycles.
  - The old value keeps scanning until commit.
  - Then digits 3..0 show 1111001, 0100100, 0110000, 0011001; ovf = 0.
- Dec load 16'd10000:
  - After commit, ovf = 1 and all digits show 0111111, dp off.
  - A following hex load of 16'h0000 clears ovf.
- With SEG7_LZB_EN, dec load 16'd7:
  - Digits 3..1 show 1111111 and digit 0 shows 1111000.
  - Without the macro, digits 3..1 show 1000000.
- Assert rst for 1 cycle at CONV iteration 8 of a dec load of 16'd4321:
  - All outputs return to reset values and load_ready = 1.
  - A subsequent hex load of 16'h00A0 works correctly.
- load_valid held high during CONV with changing load_value: only the first value is committed, and a second accept occurs the first cycle load_ready = 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   SEG_BLANK / SEG_DASH : special segment patterns (active-high form)
//   SEG_TABLE            : glyphs for nibbles 0-F, {g,f,e,d,c,b,a}, active-high
//   state_e              : load/convert controller states
//   pow10()              : 10^n as a 32-bit value, used for the overflow threshold
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  // Index 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_encode.sv
// seg7_encode: nibble to 7-segment pattern.
//   nibble : value 0-F to display
//   blank  : all segments off
//   dash   : show '-' (only g lit); wins over blank and nibble
//   seg    : {g,f,e,d,c,b,a}; polarity set by INVERT (1 = active-low)
module seg7_encode
  import seg7_pkg::*;
#(
  parameter int INVERT = 1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] seg_ah;

  always_comb begin
    seg_ah = SEG_TABLE[nibble];
    if (dash)       seg_ah = SEG_DASH;
    else if (blank) seg_ah = SEG_BLANK;
    seg = (INVERT != 0) ? ~seg_ah : seg_ah;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multi-digit 7-segment controller with time-multiplexed scan.
//   clk, rst    : clock, asynchronous active-high reset
//   load_valid  : load request; load_ready: accepting (only while IDLE)
//   load_value  : hex nibbles (load_dec=0) or unsigned binary (load_dec=1)
//   load_dp     : per-digit decimal point, 1 = lit
//   seg, dp, an : registered segment bus, decimal point, one-hot digit enable
//   ovf         : last decimal load did not fit in DIGITS decimal digits
//   dbg_state   : controller state (seg7_pkg::state_e encoding)
// Handshake: a load is taken on a rising edge where load_valid and load_ready
// are both high; the source holds load_valid/value/dec/dp until then.
// Optional macro SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int INVERT    = 1,
  parameter int ANODE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  load_dec,
  input  logic [DIGITS-1:0]     load_dp,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  ovf,
  output logic [1:0]            dbg_state
);

  localparam int          W         = 4 * DIGITS;
  localparam logic [31:0] OVF_LIMIT = pow10(DIGITS);
  localparam logic [6:0]  SEG_RST   = (INVERT != 0) ? ~SEG_TABLE[0] : SEG_TABLE[0];
  localparam logic        DP_RST    = (INVERT != 0);
  localparam logic [DIGITS-1:0] AN_RST =
    (ANODE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);

  state_e              state_q, state_d;
  logic [W-1:0]        disp_q, disp_d;
  logic [DIGITS-1:0]   dpr_q, dpr_d;
  logic                ovf_q, ovf_d;
  logic [W-1:0]        bin_q, bin_d;
  logic [W-1:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0]   dp_hold_q, dp_hold_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [5:0]          iter_q, iter_d;
  logic [31:0]         presc_q, presc_d;
  logic [2:0]          idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [2*W-1:0]      shift_v;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                cur_dp_lit;
  logic [DIGITS-1:0]   an_oh;
  logic [6:0]          seg_enc;

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  function automatic logic [W-1:0] dabble_adj(input logic [W-1:0] b);
    logic [W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Load / conversion controller.
  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    dpr_d      = dpr_q;
    ovf_d      = ovf_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    dp_hold_d  = dp_hold_q;
    ovf_pend_d = ovf_pend_q;
    iter_d     = iter_q;
    shift_v    = {dabble_adj(bcd_q), bin_q} << 1;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          if (load_dec) begin
            bin_d      = load_value;
            bcd_d      = '0;
            dp_hold_d  = load_dp;
            ovf_pend_d = (64'(load_value) >= 64'(OVF_LIMIT));
            iter_d     = '0;
            state_d    = CONV;
          end else begin
            disp_d = load_value;
            dpr_d  = load_dp;
            ovf_d  = 1'b0;
          end
        end
      end
      CONV: begin
        bcd_d  = shift_v[2*W-1:W];
        bin_d  = shift_v[W-1:0];
        iter_d = iter_q + 6'd1;
        if (iter_q == 6'(W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = bcd_q;
        dpr_d   = dp_hold_q;
        ovf_d   = ovf_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan prescaler and digit index.
  always_comb begin
    presc_d = presc_q + 32'd1;
    idx_d   = idx_q;
    if (presc_q >= 32'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Output stage: decode the current digit, registered below.
  always_comb begin
    cur_nib    = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
    // Blank when this and every higher nibble is zero; digit 0 always shows.
    cur_blank  = (idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
    cur_blank  = 1'b0;
`endif
    cur_dp_lit = dpr_q[idx_q] & ~ovf_q;
    an_oh      = DIGITS'(1) << idx_q;
    seg_d      = seg_enc;
    dp_d       = (INVERT != 0) ? ~cur_dp_lit : cur_dp_lit;
    an_d       = (ANODE_LOW != 0) ? ~an_oh : an_oh;
  end

  seg7_encode #(.INVERT(INVERT)) u_encode (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .dash   (ovf_q),
    .seg    (seg_enc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      disp_q     <= '0;
      dpr_q      <= '0;
      ovf_q      <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      dp_hold_q  <= '0;
      ovf_pend_q <= 1'b0;
      iter_q     <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_RST;
      dp_q       <= DP_RST;
      an_q       <= AN_RST;
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      dpr_q      <= dpr_d;
      ovf_q      <= ovf_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      dp_hold_q  <= dp_hold_d;
      ovf_pend_q <= ovf_pend_d;
      iter_q     <= iter_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign ovf        = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 3;
  localparam int W        = 16;

  // Active-low glyphs {g,f,e,d,c,b,a} for 0-F.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- clock / reset ----------------
  logic clk, rst;
  logic load_valid, load_ready, load_dec, dp, ovf;
  logic [W-1:0] load_value;
  logic [DIGITS-1:0] load_dp, an;
  logic [6:0] seg;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .INVERT(1), .ANODE_LOW(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dec   (load_dec),
    .load_dp    (load_dp),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .ovf        (ovf),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]      m_disp;
  logic [DIGITS-1:0] m_dp, m_pend_dp;
  logic              m_ovf;
  int                m_busy;
  int                m_n;
  logic [6:0]        exp_seg;
  logic              exp_dp;
  logic [DIGITS-1:0] exp_an;
  logic [W-1:0]      exp_q[$];  // decimal loads waiting to commit

  function automatic logic [W-1:0] to_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((int'(v) / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int scan_idx(input int n);
    return (n / SCAN_DIV) % DIGITS;
  endfunction

  function automatic logic [6:0] model_seg(input logic [W-1:0] d, input logic o, input int i);
    logic [3:0] nib;
    if (o) return 7'b0111111;
    nib = d[4*i +: 4];
`ifdef SEG7_LZB_EN
    if (i != 0 && (d >> (4*i)) == 0) return 7'b1111111;
`endif
    return GLYPH[nib];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_disp    <= '0;
      m_dp      <= '0;
      m_pend_dp <= '0;
      m_ovf     <= 1'b0;
      m_busy    <= 0;
      m_n       <= 0;
      exp_seg   <= 7'b1000000;
      exp_dp    <= 1'b1;
      exp_an    <= 4'b1110;
      exp_q.delete();
    end else begin
      exp_seg <= model_seg(m_disp, m_ovf, scan_idx(m_n));
      exp_dp  <= m_ovf ? 1'b1 : ~m_dp[scan_idx(m_n)];
      exp_an  <= ~(4'b0001 << scan_idx(m_n));
      m_n     <= m_n + 1;
      if (m_busy != 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1 && exp_q.size() > 0) begin
          m_disp <= to_bcd(exp_q[0]);
          m_ovf  <= (int'(exp_q[0]) >= 10000);
          m_dp   <= m_pend_dp;
          exp_q.delete(0);
        end
      end else if (load_valid) begin
        if (load_dec) begin
          exp_q.push_back(load_value);
          m_pend_dp <= load_dp;
          m_busy    <= W + 1;
        end else begin
          m_disp <= load_value;
          m_dp   <= load_dp;
          m_ovf  <= 1'b0;
        end
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready", {31'b0, load_ready}, {31'b0, (m_busy == 0)});
      check("ovf",   {31'b0, ovf},        {31'b0, m_ovf});
      check("seg",   {25'b0, seg},        {25'b0, exp_seg});
      check("dp",    {31'b0, dp},         {31'b0, exp_dp});
      check("an",    {28'b0, an},         {28'b0, exp_an});
      check("an_onehot", $countones(~an), 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [W-1:0] v, input logic dec, input logic [DIGITS-1:0] dpv);
    int g;
    @(negedge clk);
    load_value = v;
    load_dec   = dec;
    load_dp    = dpv;
    load_valid = 1'b1;
    g = 0;
    while (!load_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("load_timeout", 1, 0);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!load_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("ready_timeout", 1, 0);
  endtask

  task automatic check_digit(input int k, input logic [6:0] want, input string name);
    int g = 0;
    logic [3:0] want_an;
    want_an = ~(4'b0001 << k);
    while (an !== want_an && g < 40) begin
      @(negedge clk);
      g++;
    end
    check({name, "_an"}, {28'b0, an}, {28'b0, want_an});
    check(name, {25'b0, seg}, {25'b0, want});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [6:0] lead;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    load_dec   = 1'b0;
    load_dp    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_seg",   {25'b0, seg}, 32'h40);
    check("rst_an",    {28'b0, an},  32'he);
    check("rst_dp",    {31'b0, dp},  32'h1);
    check("rst_ready", {31'b0, load_ready}, 32'h1);
    check("rst_ovf",   {31'b0, ovf}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Hex BEEF: glyphs, dwell and steady ready.
    do_load(16'hBEEF, 1'b0, 4'b0000);
    @(negedge clk);
    check_digit(0, 7'b0001110, "beef_d0");
    check_digit(1, 7'b0000110, "beef_d1");
    check_digit(2, 7'b0000110, "beef_d2");
    check_digit(3, 7'b0000011, "beef_d3");
    check_digit(0, 7'b0001110, "beef_d0b");
    cnt = 0;
    while (an === 4'b1110 && cnt < 20) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (an === 4'b1101 && cnt < 20) begin @(negedge clk); cnt++; end
    check("dwell", cnt, 3);

    // Dec 1234: ready low W+1 cycles.
    do_load(16'd1234, 1'b1, 4'b0000);
    cnt = 0;
    while (!load_ready && cnt < 100) begin cnt++; @(negedge clk); end
    check("busy_len", cnt, 17);
    @(negedge clk);
    check_digit(3, 7'b1111001, "d1234_3");
    check_digit(2, 7'b0100100, "d1234_2");
    check_digit(1, 7'b0110000, "d1234_1");
    check_digit(0, 7'b0011001, "d1234_0");
    check("d1234_ovf", {31'b0, ovf}, 0);

    // Dec 10000: overflow dashes, then hex clears it.
    do_load(16'd10000, 1'b1, 4'b1111);
    wait_ready();
    @(negedge clk);
    check("ovf_set", {31'b0, ovf}, 1);
    for (int k = 0; k < DIGITS; k++) begin
      check_digit(k, 7'b0111111, "ovf_dash");
      check("ovf_dp", {31'b0, dp}, 1);
    end
    do_load(16'h0000, 1'b0, 4'b0000);
    check("ovf_clr", {31'b0, ovf}, 0);

    // Dec 7: leading digits.
`ifdef SEG7_LZB_EN
    lead = 7'b1111111;
`else
    lead = 7'b1000000;
`endif
    do_load(16'd7, 1'b1, 4'b0000);
    wait_ready();
    @(negedge clk);
    check_digit(3, lead, "d7_3");
    check_digit(2, lead, "d7_2");
    check_digit(1, lead, "d7_1");
    check_digit(0, 7'b1111000, "d7_0");

    // Reset during conversion of 4321.
    @(negedge clk);
    load_value = 16'd4321;
    load_dec   = 1'b1;
    load_dp    = 4'b0101;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_seg",   {25'b0, seg}, 32'h40);
    check("mid_rst_an",    {28'b0, an},  32'he);
    check("mid_rst_dp",    {31'b0, dp},  32'h1);
    check("mid_rst_ready", {31'b0, load_ready}, 32'h1);
    check("mid_rst_ovf",   {31'b0, ovf}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_load(16'h00A0, 1'b0, 4'b0000);
    @(negedge clk);
    check_digit(1, 7'b0001000, "a0_1");
    check_digit(0, 7'b1000000, "a0_0");
    check_digit(3, lead, "a0_3");

    // Held request during conversion: first value commits, second accepted
    // on the first ready cycle.
    @(negedge clk);
    load_value = 16'd5678;
    load_dec   = 1'b1;
    load_dp    = 4'b0000;
    load_valid = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (!load_ready && cnt < 100) begin
      load_value = 16'($urandom_range(0, 65535));
      load_dec   = 1'($urandom_range(0, 1));
      @(negedge clk);
      cnt++;
    end
    check("held_busy", cnt, 17);
    load_value = 16'd9;
    load_dec   = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check("held_second_accept", {31'b0, load_ready}, 0);
    wait_ready();
    @(negedge clk);
    check_digit(0, 7'b0010000, "held_d0");

    // Random loads.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_load(16'($urandom_range(0, 12000)), 1'b1, 4'($urandom_range(0, 15)));
      else
        do_load(16'($urandom_range(0, 65535)), 1'b0, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    wait_ready();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
